// File: rtl/core_boot_controller.sv
// Launch sequencer for one RISC-V core: reset hold, start pulse, cycle count until halt, report pulse, result handshake.
// Optional watchdog on the run phase is compiled in with `define BOOT_TIMEOUT_EN.
module core_boot_controller #(
  parameter int ADDRESS_BITS   = 20,
  parameter int CYCLE_BITS     = 32,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDRESS_BITS-1:0] cmd_address,
  output logic                    core_reset,
  output logic                    core_start,
  output logic [ADDRESS_BITS-1:0] core_prog_address,
  output logic                    core_report,
  input  logic                    core_halt,
  output logic                    done_valid,
  input  logic                    done_ready,
  output logic [CYCLE_BITS-1:0]   done_cycles,
  output logic                    done_timeout
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RESET  = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_REPORT = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam int                    RST_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RST_W-1:0]      RST_LOAD = RST_W'(RESET_CYCLES - 1);
  localparam logic [RST_W-1:0]      RST_ONE  = RST_W'(1);
  localparam logic [CYCLE_BITS-1:0] CNT_ONE  = CYCLE_BITS'(1);
  localparam logic [CYCLE_BITS-1:0] CNT_MAX  = '1;

  if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
    $error("core_boot_controller: RESET_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
    $error("core_boot_controller: TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0]              state_q, state_d;
  logic [RST_W-1:0]        rst_cnt_q, rst_cnt_d;
  logic [CYCLE_BITS-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic                    timeout_hit;

  logic                    core_reset_q, core_reset_d;
  logic                    core_start_q, core_start_d;
  logic [ADDRESS_BITS-1:0] prog_addr_q, prog_addr_d;
  logic                    core_report_q, core_report_d;
  logic                    done_valid_q, done_valid_d;
  logic [CYCLE_BITS-1:0]   done_cycles_q, done_cycles_d;
  logic                    done_timeout_q, done_timeout_d;

  // Run counter sticks at all-ones rather than wrapping.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

`ifdef BOOT_TIMEOUT_EN
  localparam logic [CYCLE_BITS-1:0] TIMEOUT_VAL = CYCLE_BITS'(TIMEOUT_CYCLES);

  if (CYCLE_BITS < 32 && TIMEOUT_CYCLES >= (1 << CYCLE_BITS)) begin : g_bad_timeout_width
    $error("core_boot_controller: TIMEOUT_CYCLES does not fit in CYCLE_BITS");
  end

  assign timeout_hit = (cnt_inc == TIMEOUT_VAL);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    prog_addr_d    = prog_addr_q;
    done_cycles_d  = done_cycles_q;
    done_timeout_d = done_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_address;
          cnt_d     = '0;
          rst_cnt_d = RST_LOAD;
          state_d   = ST_RESET;
        end
      end
      ST_RESET: begin
        if (rst_cnt_q == '0) begin
          prog_addr_d = addr_q;
          state_d     = ST_START;
        end else begin
          rst_cnt_d = rst_cnt_q - RST_ONE;
        end
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        cnt_d = cnt_inc;
        // A halt in the same cycle as the watchdog expiry is a normal finish.
        if (core_halt || timeout_hit) begin
          done_cycles_d  = cnt_inc;
          done_timeout_d = timeout_hit & ~core_halt;
          state_d        = ST_REPORT;
        end
      end
      ST_REPORT: state_d = ST_DONE;
      ST_DONE: begin
        if (done_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line up with the state.
    core_reset_d  = (state_d == ST_IDLE) || (state_d == ST_RESET);
    core_start_d  = (state_d == ST_START);
    core_report_d = (state_d == ST_REPORT);
    done_valid_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so all registers sample the same pre-edge values.
    if (reset) begin
      state_q        <= ST_IDLE;
      rst_cnt_q      <= '0;
      cnt_q          <= '0;
      addr_q         <= '0;
      core_reset_q   <= 1'b1;
      core_start_q   <= 1'b0;
      prog_addr_q    <= '0;
      core_report_q  <= 1'b0;
      done_valid_q   <= 1'b0;
      done_cycles_q  <= '0;
      done_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      core_reset_q   <= core_reset_d;
      core_start_q   <= core_start_d;
      prog_addr_q    <= prog_addr_d;
      core_report_q  <= core_report_d;
      done_valid_q   <= done_valid_d;
      done_cycles_q  <= done_cycles_d;
      done_timeout_q <= done_timeout_d;
    end
  end

  assign cmd_ready         = (state_q == ST_IDLE) & ~reset;
  assign core_reset        = core_reset_q;
  assign core_start        = core_start_q;
  assign core_prog_address = prog_addr_q;
  assign core_report       = core_report_q;
  assign done_valid        = done_valid_q;
  assign done_cycles       = done_cycles_q;
  assign done_timeout      = done_timeout_q;

endmodule

// File: tb/tb_core_boot_controller.sv
// Directed bench for core_boot_controller; expectations adapt when BOOT_TIMEOUT_EN is defined.
module tb_core_boot_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [19:0] cmd_address;
  logic        core_reset;
  logic        core_start;
  logic [19:0] core_prog_address;
  logic        core_report;
  logic        core_halt;
  logic        done_valid;
  logic        done_ready;
  logic [31:0] done_cycles;
  logic        done_timeout;

  logic        s_cmd_valid;
  logic        s_cmd_ready;
  logic [19:0] s_cmd_address;
  logic        s_core_reset;
  logic        s_core_start;
  logic [19:0] s_core_prog_address;
  logic        s_core_report;
  logic        s_core_halt;
  logic        s_done_valid;
  logic        s_done_ready;
  logic [3:0]  s_done_cycles;
  logic        s_done_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  core_boot_controller #(
    .ADDRESS_BITS(20), .CYCLE_BITS(32), .RESET_CYCLES(4), .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_address(cmd_address),
    .core_reset(core_reset), .core_start(core_start), .core_prog_address(core_prog_address),
    .core_report(core_report), .core_halt(core_halt),
    .done_valid(done_valid), .done_ready(done_ready), .done_cycles(done_cycles),
    .done_timeout(done_timeout)
  );

  core_boot_controller #(
    .ADDRESS_BITS(20), .CYCLE_BITS(4), .RESET_CYCLES(4), .TIMEOUT_CYCLES(8)
  ) u_dut_sat (
    .clock(clock), .reset(reset),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_address(s_cmd_address),
    .core_reset(s_core_reset), .core_start(s_core_start), .core_prog_address(s_core_prog_address),
    .core_report(s_core_report), .core_halt(s_core_halt),
    .done_valid(s_done_valid), .done_ready(s_done_ready), .done_cycles(s_done_cycles),
    .done_timeout(s_done_timeout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge with the DUT idle. halt_neg is the falling-edge index
  // (counted from the handshake) at which core_halt is raised; the START cycle is index 5.
  task automatic launch(input logic [19:0] addr, input int halt_neg, input int exp_cycles,
                        input logic exp_to, input string tag);
    int          rst_hi    = 0;
    int          starts    = 0;
    int          start_at  = -1;
    int          reports   = 0;
    int          report_at = -1;
    int          done_at   = -1;
    logic [19:0] addr_seen = '0;
    logic        rst_at_start = 1'b1;
    check({tag, ".cmd_ready"}, cmd_ready, 1'b1);
    cmd_valid   = 1'b1;
    cmd_address = addr;
    for (int k = 1; k <= 300 && done_at < 0; k++) begin
      @(negedge clock);
      cmd_valid = 1'b0;
      if (k == halt_neg) core_halt = 1'b1;
      if (core_reset && starts == 0) rst_hi++;
      if (core_start) begin
        starts++;
        start_at     = k;
        addr_seen    = core_prog_address;
        rst_at_start = core_reset;
      end
      if (core_report) begin
        reports++;
        report_at = k;
      end
      if (done_valid) done_at = k;
    end
    check({tag, ".reset_hold"}, rst_hi, 4);
    check({tag, ".start_count"}, starts, 1);
    check({tag, ".start_at"}, start_at, 5);
    check({tag, ".reset_in_start"}, rst_at_start, 1'b0);
    check({tag, ".prog_address"}, addr_seen, addr);
    check({tag, ".report_count"}, reports, 1);
    check({tag, ".report_at"}, report_at, 5 + exp_cycles + 1);
    check({tag, ".done_at"}, done_at, 5 + exp_cycles + 2);
    check({tag, ".done_cycles"}, done_cycles, exp_cycles);
    check({tag, ".done_timeout"}, done_timeout, exp_to);
  endtask

  // Holds done_ready low for 'hold' cycles while poking cmd_valid, then completes the handshake.
  task automatic release_done(input int hold, input logic [31:0] exp_cycles, input string tag);
    int bad = 0;
    core_halt = 1'b0;
    for (int i = 0; i < hold; i++) begin
      cmd_valid   = 1'b1;
      cmd_address = 20'h77777;
      @(negedge clock);
      if (done_valid !== 1'b1 || done_cycles !== exp_cycles || cmd_ready !== 1'b0 ||
          core_start !== 1'b0 || core_reset !== 1'b0) bad++;
    end
    cmd_valid = 1'b0;
    check({tag, ".hold_stable"}, bad, 0);
    check({tag, ".valid_before"}, done_valid, 1'b1);
    done_ready = 1'b1;
    @(negedge clock);
    done_ready = 1'b0;
    check({tag, ".valid_after"}, done_valid, 1'b0);
    check({tag, ".ready_after"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int reports;
    int sdone_at;
    reset         = 1'b1;
    cmd_valid     = 1'b0;
    cmd_address   = '0;
    core_halt     = 1'b0;
    done_ready    = 1'b0;
    s_cmd_valid   = 1'b0;
    s_cmd_address = '0;
    s_core_halt   = 1'b0;
    s_done_ready  = 1'b0;

    repeat (3) @(negedge clock);
    check("rst.cmd_ready", cmd_ready, 1'b0);
    check("rst.core_reset", core_reset, 1'b1);
    check("rst.core_start", core_start, 1'b0);
    check("rst.prog_address", core_prog_address, 20'h0);
    check("rst.core_report", core_report, 1'b0);
    check("rst.done_valid", done_valid, 1'b0);
    check("rst.done_cycles", done_cycles, 32'd0);
    check("rst.done_timeout", done_timeout, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check("idle.cmd_ready", cmd_ready, 1'b1);
    check("idle.core_reset", core_reset, 1'b1);

    // Basic launch, halt in the 10th run cycle.
    launch(20'h00000, 15, 10, 1'b0, "t1");
    release_done(0, 32'd10, "t1");

    // Halt already high during reset and START: only the first run cycle counts.
    launch(20'hABCDE, 3, 1, 1'b0, "t2");
    release_done(20, 32'd1, "t3");

    // Launch immediately after the result handshake.
    launch(20'h12345, 12, 7, 1'b0, "t3b");
    release_done(0, 32'd7, "t3b");

    // Reset asserted in the 5th run cycle.
    reports     = 0;
    cmd_valid   = 1'b1;
    cmd_address = 20'h55555;
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (9) begin
      @(negedge clock);
      if (core_report) reports++;
    end
    check("t4.running_reset", core_reset, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    if (core_report) reports++;
    check("t4.core_reset", core_reset, 1'b1);
    check("t4.done_valid", done_valid, 1'b0);
    check("t4.core_start", core_start, 1'b0);
    check("t4.prog_address", core_prog_address, 20'h0);
    check("t4.cmd_ready_in_reset", cmd_ready, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    if (core_report) reports++;
    check("t4.cmd_ready", cmd_ready, 1'b1);
    check("t4.done_cycles", done_cycles, 32'd0);
    check("t4.no_report", reports, 0);

    // Watchdog boundary: halt at run cycle 16 is a normal finish in either build.
    launch(20'h0F0F0, 21, 16, 1'b0, "t5_halt16");
    release_done(0, 32'd16, "t5_halt16");
`ifdef BOOT_TIMEOUT_EN
    launch(20'h0F0F1, 1000, 16, 1'b1, "t5_timeout");
    release_done(0, 32'd16, "t5_timeout");
`else
    launch(20'h0F0F1, 25, 20, 1'b0, "t5_no_wdog");
    release_done(0, 32'd20, "t5_no_wdog");
`endif

    // Narrow counter saturates at 15.
    sdone_at      = -1;
    s_cmd_valid   = 1'b1;
    s_cmd_address = 20'h00042;
    @(negedge clock);
    s_cmd_valid = 1'b0;
    for (int k = 1; k <= 100 && sdone_at < 0; k++) begin
      @(negedge clock);
      if (k == 25) s_core_halt = 1'b1;
      if (s_done_valid) sdone_at = k;
    end
`ifdef BOOT_TIMEOUT_EN
    check("t6.done_at", sdone_at, 15);
    check("t6.done_cycles", s_done_cycles, 4'd8);
    check("t6.done_timeout", s_done_timeout, 1'b1);
`else
    check("t6.done_at", sdone_at, 27);
    check("t6.done_cycles", s_done_cycles, 4'd15);
    check("t6.done_timeout", s_done_timeout, 1'b0);
`endif
    s_core_halt  = 1'b0;
    s_done_ready = 1'b1;
    @(negedge clock);
    s_done_ready = 1'b0;
    check("t6.valid_after", s_done_valid, 1'b0);
    check("t6.ready_after", s_cmd_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
